openofdm_rx_word_packer: RTL

- Sits directly downstream of the OFDM receiver core.
- Consumes the decoded byte stream, the SIGNAL/HT-SIG header fields, the FCS result and RSSI.
- Emits one AXI-Stream-style packet of 64-bit words per received PPDU: header word, payload words, status word with tlast.
- An internal FIFO decouples the non-stallable receiver from the DMA side; overflow is detected and reported, never silently lost.

---
 rtl/openofdm_rx_word_packer.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/openofdm_rx_word_packer.sv
// Packs the OFDM receiver byte stream into 64-bit words framed as header / payload / status,
// buffered in a first-word-fall-through FIFO with one slot held back for status words.
module openofdm_rx_word_packer #(
   parameter int RSSI_HALF_DB_WIDTH = 11,
   parameter int FIFO_DEPTH_LOG2    = 4
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
   input  logic                                 pkt_header_valid,
   input  logic                                 pkt_header_valid_strobe,
   input  logic                                 ht_unsupport,
   input  logic        [7:0]                    pkt_rate,
   input  logic        [15:0]                   pkt_len,
   input  logic                                 ht_aggr,
   input  logic                                 ht_aggr_last,
   input  logic                                 ht_sgi,
   input  logic                                 byte_out_strobe,
   input  logic        [7:0]                    byte_out,
   input  logic                                 fcs_out_strobe,
   input  logic                                 fcs_ok,
   output logic        [63:0]                   m_axis_tdata,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast,
   output logic                                 busy,
   output logic        [15:0]                   pkt_drop_cnt
);

   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] RESV_C = {1'b0, {AW{1'b1}}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      PAYLOAD = 3'd2,
      FLUSH   = 3'd3,
      STATUS  = 3'd4
   } state_t;

   typedef struct packed {
      logic [15:0] len;
      logic [7:0]  rate;
      logic [15:0] rssi;
      logic        sgi;
      logic        aggr_last;
      logic        aggr;
      logic        unsup;
   } hdr_t;

   localparam hdr_t HDR_ZERO_C = '{len: 16'd0, rate: 8'd0, rssi: 16'd0, sgi: 1'b0,
                                   aggr_last: 1'b0, aggr: 1'b0, unsup: 1'b0};

   state_t        state_r;
   hdr_t          hdr_r;
   hdr_t          pend_r;
   hdr_t          hdr_in_s;
   logic          pend_v_r;
   logic [63:0]   word_r;
   logic [2:0]    lane_r;
   logic          full_r;
   logic [15:0]   byte_cnt_r;
   logic          fcs_r;
   logic          aborted_r;
   logic          ovf_r;
   logic [15:0]   drop_cnt_r;
   logic          busy_r;
   logic          hdr_hit_s;
   logic          start_s;

   logic          wr_req_s;
   logic          wr_status_s;
   logic [64:0]   wr_data_s;
   logic          wr_ok_s;
   logic          refuse_s;

   logic [64:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] rd_ptr_nxt_s;
   logic [AW:0]   count_r;
   logic [AW:0]   occ_s;
   logic [AW:0]   cnt_nxt_s;
   logic          rd_fire_s;
   logic [64:0]   out_r;
   logic          tvalid_r;

   assign m_axis_tdata  = out_r[63:0];
   assign m_axis_tlast  = out_r[64];
   assign m_axis_tvalid = tvalid_r;
   assign busy          = busy_r;
   assign pkt_drop_cnt  = drop_cnt_r;

   // Header inputs as they would be latched this cycle; the sized cast sign-extends RSSI.
   always_comb begin
      hdr_in_s.len       = pkt_len;
      hdr_in_s.rate      = pkt_rate;
      hdr_in_s.rssi      = 16'(rssi_half_db);
      hdr_in_s.sgi       = ht_sgi;
      hdr_in_s.aggr_last = ht_aggr_last;
      hdr_in_s.aggr      = ht_aggr;
      hdr_in_s.unsup     = ht_unsupport;
   end

   // Packet start: a fresh header in IDLE, or a new/pending header when STATUS completes.
   always_comb begin
      hdr_hit_s = pkt_header_valid_strobe & pkt_header_valid;
      if (state_r == IDLE) begin
         start_s = hdr_hit_s;
      end else if (state_r == STATUS) begin
         start_s = hdr_hit_s | pend_v_r;
      end else begin
         start_s = 1'b0;
      end
   end

   // FIFO write request for the current state (at most one word per cycle).
   always_comb begin
      wr_req_s    = 1'b0;
      wr_status_s = 1'b0;
      wr_data_s   = 65'd0;
      case (state_r)
         HDR: begin
            wr_req_s  = 1'b1;
            wr_data_s = {1'b0, hdr_r.len, hdr_r.rate, 4'd0, hdr_r.sgi, hdr_r.aggr_last,
                         hdr_r.aggr, hdr_r.unsup, hdr_r.rssi, 16'hA5A5};
         end
         PAYLOAD: begin
            if (full_r) begin
               wr_req_s  = 1'b1;
               wr_data_s = {1'b0, word_r};
            end else begin
               wr_req_s  = 1'b0;
            end
         end
         FLUSH: begin
            if (full_r || (lane_r != 3'd0)) begin
               wr_req_s  = 1'b1;
               wr_data_s = {1'b0, word_r};
            end else begin
               wr_req_s  = 1'b0;
            end
         end
         STATUS: begin
            wr_req_s    = 1'b1;
            wr_status_s = 1'b1;
            wr_data_s   = {1'b1, byte_cnt_r, 45'd0, aborted_r, ovf_r, fcs_r & ~aborted_r};
         end
         default: begin
            wr_req_s = 1'b0;
         end
      endcase
   end

   // Admission: occupancy after this cycle's read; non-status words must leave one slot free.
   always_comb begin
      rd_fire_s    = tvalid_r & m_axis_tready;
      occ_s        = count_r - (AW+1)'(rd_fire_s);
      rd_ptr_nxt_s = rd_ptr_r + AW'(rd_fire_s);
      if (wr_status_s) begin
         wr_ok_s = wr_req_s & (occ_s < FULL_C);
      end else begin
         wr_ok_s = wr_req_s & (occ_s < RESV_C);
      end
      refuse_s  = wr_req_s & ~wr_ok_s;
      cnt_nxt_s = occ_s + (AW+1)'(wr_ok_s);
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   // FIFO pointers and registered head-of-queue output.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
         out_r    <= 65'd0;
         tvalid_r <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= cnt_nxt_s;
         tvalid_r <= (cnt_nxt_s != {(AW+1){1'b0}});
         // A word written into an empty (or just-emptied) FIFO bypasses straight to the head.
         if (occ_s != {(AW+1){1'b0}}) begin
            out_r <= mem_r[rd_ptr_nxt_s];
         end else if (wr_ok_s) begin
            out_r <= wr_data_s;
         end else begin
            out_r <= 65'd0;
         end
      end
   end

   // Framing FSM: byte lanes, per-packet flags, pending header and drop counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= IDLE;
         hdr_r      <= HDR_ZERO_C;
         pend_r     <= HDR_ZERO_C;
         pend_v_r   <= 1'b0;
         word_r     <= 64'd0;
         lane_r     <= 3'd0;
         full_r     <= 1'b0;
         byte_cnt_r <= 16'd0;
         fcs_r      <= 1'b0;
         aborted_r  <= 1'b0;
         ovf_r      <= 1'b0;
         drop_cnt_r <= 16'd0;
         busy_r     <= 1'b0;
      end else begin
         full_r <= 1'b0;
         if (refuse_s) begin
            if (wr_status_s) begin
               if (drop_cnt_r != 16'hFFFF) begin
                  drop_cnt_r <= drop_cnt_r + 16'd1;
               end
            end else begin
               ovf_r <= 1'b1;
            end
         end
         if (hdr_hit_s && ((state_r == PAYLOAD) || (state_r == FLUSH))) begin
            pend_r   <= hdr_in_s;
            pend_v_r <= 1'b1;
         end
         if (start_s) begin
            hdr_r      <= hdr_hit_s ? hdr_in_s : pend_r;
            pend_v_r   <= 1'b0;
            byte_cnt_r <= 16'd0;
            ovf_r      <= 1'b0;
            aborted_r  <= 1'b0;
            fcs_r      <= 1'b0;
            lane_r     <= 3'd0;
            word_r     <= 64'd0;
         end
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= HDR;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            HDR: begin
               state_r <= PAYLOAD;
               busy_r  <= 1'b1;
            end
            PAYLOAD: begin
               if (byte_out_strobe) begin
                  // Lane 0 clears the upper lanes so a later partial word is zero-padded.
                  if (lane_r == 3'd0) begin
                     word_r <= {56'd0, byte_out};
                  end else begin
                     word_r[{lane_r, 3'b000} +: 8] <= byte_out;
                  end
                  full_r     <= (lane_r == 3'd7);
                  lane_r     <= lane_r + 3'd1;
                  byte_cnt_r <= byte_cnt_r + 16'd1;
               end
               if (hdr_hit_s) begin
                  aborted_r <= 1'b1;
                  state_r   <= FLUSH;
               end else if (fcs_out_strobe) begin
                  fcs_r   <= fcs_ok;
                  state_r <= FLUSH;
               end
            end
            FLUSH: begin
               lane_r  <= 3'd0;
               state_r <= STATUS;
            end
            STATUS: begin
               if (start_s) begin
                  state_r <= HDR;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
